matmul_stream: RTL and testbench
================================

// Module: matmul_stream
// PURPOSE
//  Streaming, handshaked successor to the combinational matrix multiplier: computes C = A*B,
//  with A = LEFT x MIDDLE and B = MIDDLE x RIGHT, by outer-product accumulation.
//  Each accepted beat carries one column of A and the matching row of B; after MIDDLE beats,
//  the LEFT x RIGHT result is held until the consumer takes it. Used between operand buffers
//  and the activation stage of the accelerator datapath.
// PARAMETERS
//  LEFT_SIZE    2                           rows of A and C
//  MIDDLE_SIZE  3                           shared dimension = beats per matrix
//  RIGHT_SIZE   4                           columns of B and C
//  DATA_W       16                          operand width
//  ACC_W        2*DATA_W+$clog2(MIDDLE_SIZE) accumulator/result width; overflow-free at default
//  SIGNED       1                           1 = two's-complement operands, 0 = unsigned
// PORTS
//  clk        in   1                            clock, rising edge
//  rst_n      in   1                            async active-low reset
//  clear      in   1                            sync flush: abort partial sum, drop held result
//  in_valid   in   1                            beat valid
//  in_ready   out  1                            beat accepted when in_valid && in_ready
//  a_col      in   [DATA_W-1:0] x [LEFT_SIZE]   A[:,k] for current beat k
//  b_row      in   [DATA_W-1:0] x [RIGHT_SIZE]  B[k,:] for current beat k
//  out_valid  out  1                            result[][] holds a complete C
//  out_ready  in   1                            result consumed when out_valid && out_ready
//  result     out  [ACC_W-1:0] x [LEFT_SIZE][RIGHT_SIZE]  C[i][j], registered
//  busy       out  1                            partial sum in progress (beat count != 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): beat counter k=0, out_valid=0, busy=0, all result=0.
//  - in_ready = !clear && (!out_valid || out_ready); combinational, no in_valid dependency.
//  - Accepted beat with k==0: acc[i][j] <= a_col[i]*b_row[j] (load, no separate clear cycle).
//    With k>0: acc[i][j] <= acc[i][j] + a_col[i]*b_row[j].
//  - Products/sums are sign- or zero-extended to ACC_W per SIGNED. A smaller ACC_W wraps mod 2^ACC_W.
//  - k increments per accepted beat. On the MIDDLE_SIZE-th beat, k wraps to 0, out_valid<=1.
//    result is visible the cycle after that edge (latency 1 from the last beat).
//  - out_valid stays 1 and result is stable until an out_ready handshake. No beat is accepted
//    while the result is held unconsumed.
//  - Simultaneous output handshake and k==0 input beat: both happen on the same edge.
//    The consumer samples the old C; acc loads the new first product. out_valid<=0 unless
//    MIDDLE_SIZE==1, in which case out_valid stays 1 with the new C. Back-to-back throughput
//    is 1 beat/cycle.
//  - clear=1: k<=0, out_valid<=0 next edge; in_ready=0 so no beat is lost silently.
//    clear has priority over all handshakes. acc contents are don't-care after clear.
//  - in_valid is ignored when in_ready=0. Beats are never partially accepted.
//  - Reset mid-matrix or mid-hold discards all state; the first beat after reset is k=0.
//  - busy = (k != 0).
//  - Control FSM is implicit: IDLE (k==0, !out_valid), ACCUM (k!=0), HOLD (out_valid).
// STRUCTURE
//  - Package matmul_pkg: function acc_ext(x, signed_mode) for width extension; state enum
//    {IDLE, ACCUM, HOLD}; localparam K_W = $clog2(MIDDLE_SIZE) (min 1).
//  - Sub-module outer_mac_pe: one accumulator cell (multiply, load/add select, ACC_W register).
//    Instanced LEFT_SIZE x RIGHT_SIZE via generate; top holds counter, handshake and clear logic.
// TESTING
//  1 Default params, A=[[1,2,3],[4,5,6]], B=rows 1..12, in_valid held high, out_ready=1
//    -> after 3 beats C=[[38,44,50,56],[83,98,113,128]], out_valid high exactly 1 cycle.
//  2 SIGNED=1, A all -1, B all 32767 -> every C = -98301. SIGNED=0, A all 16'hFFFF,
//    B all 16'hFFFF -> 3*(65535^2).
//  3 out_ready=0 for 5 cycles after completion -> result stable, in_ready=0, in_valid beats
//    ignored; out_ready=1 -> handshake, in_ready returns high.
//  4 Two matrices back-to-back with out_ready=1 and a beat on the handshake cycle
//    -> 6 beats in 6 cycles, both C correct, no bubble.
//  5 clear asserted after beat 2 (busy=1), then a new matrix -> old partials discarded,
//    new C correct. Same with rst_n pulsed low mid-matrix -> all outputs 0 during reset.
//  6 ACC_W=8, unsigned, A=B=all 16 -> 768 mod 256 = 0 in every C (wrap check).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the streaming outer-product matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_MIDDLE_SIZE = 3;
    localparam int EXT_MAX_W       = 128;

    function automatic int k_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int K_W = k_width(DEF_MIDDLE_SIZE);

    // Extends the value whose top bit sits at msb to EXT_MAX_W bits.
    function automatic logic [EXT_MAX_W-1:0] acc_ext(
        input logic [EXT_MAX_W-1:0] x,
        input logic [6:0]           msb,
        input logic                 signed_mode
    );
        logic [EXT_MAX_W-1:0] hi_mask;
        hi_mask = ({EXT_MAX_W{1'b1}} << msb) << 1;
        if (signed_mode && x[msb]) begin
            return x | hi_mask;
        end
        return x & ~hi_mask;
    endfunction

endpackage

// File: rtl/outer_mac_pe.sv
// One C[i][j] accumulator cell: a*b product, either loaded (first beat) or added.
module outer_mac_pe
    import matmul_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 34,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic                   w_a_sign;
    logic                   w_b_sign;
    logic [2*DATA_W-1:0]    w_a_ext;
    logic [2*DATA_W-1:0]    w_b_ext;
    logic [2*DATA_W-1:0]    w_prod;
    logic [EXT_MAX_W-1:0]   w_prod_full;
    logic [ACC_W-1:0]       w_term;
    logic [ACC_W-1:0]       w_acc_next;
    logic                   w_unused_hi;
    logic [ACC_W-1:0]       r_acc;

    assign w_a_sign = (SIGNED != 0) && i_a[DATA_W-1];
    assign w_b_sign = (SIGNED != 0) && i_b[DATA_W-1];
    assign w_a_ext  = {{DATA_W{w_a_sign}}, i_a};
    assign w_b_ext  = {{DATA_W{w_b_sign}}, i_b};

    // Low 2*DATA_W bits of the extended product equal the exact product in both modes.
    assign w_prod      = w_a_ext * w_b_ext;
    assign w_prod_full = acc_ext(EXT_MAX_W'(w_prod), 7'(2*DATA_W-1), SIGNED != 0);
    assign w_term      = w_prod_full[ACC_W-1:0];
    assign w_unused_hi = ^w_prod_full[EXT_MAX_W-1:ACC_W];

    assign w_acc_next = i_load ? w_term : (r_acc + w_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/matmul_stream.sv
// Streaming C = A*B by outer-product accumulation: one A column + B row per beat,
// result held after MIDDLE_SIZE beats until the consumer handshakes it.
module matmul_stream
    import matmul_pkg::*;
#(
    parameter int LEFT_SIZE   = 2,
    parameter int MIDDLE_SIZE = 3,
    parameter int RIGHT_SIZE  = 4,
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 2*DATA_W + $clog2(MIDDLE_SIZE),
    parameter int SIGNED      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_col [LEFT_SIZE],
    input  logic [DATA_W-1:0] b_row [RIGHT_SIZE],
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result [LEFT_SIZE][RIGHT_SIZE],
    output logic              busy
);

    localparam int            KW     = k_width(MIDDLE_SIZE);
    localparam logic [KW-1:0] K_LAST = KW'(MIDDLE_SIZE - 1);

    state_e        r_state;
    state_e        w_state_next;
    logic [KW-1:0] r_k;
    logic          w_beat;
    logic          w_last;
    logic          w_load;

    assign w_beat = in_valid && in_ready;
    assign w_last = (r_k == K_LAST);
    assign w_load = (r_k == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A beat on the handshake cycle overrides the drop back to IDLE.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            if ((r_state == HOLD) && out_ready) begin
                w_state_next = IDLE;
            end
            if (w_beat) begin
                w_state_next = w_last ? HOLD : ACCUM;
            end
        end
    end

    always_comb begin
        in_ready  = !clear && ((r_state != HOLD) || out_ready);
        out_valid = (r_state == HOLD);
        busy      = (r_k != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
        end else if (clear) begin
            r_k <= '0;
        end else if (w_beat) begin
            r_k <= w_last ? '0 : (r_k + 1'b1);
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < LEFT_SIZE; gi++) begin : g_row
            for (gj = 0; gj < RIGHT_SIZE; gj++) begin : g_col
                outer_mac_pe #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W),
                    .SIGNED (SIGNED)
                ) u_pe (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .i_en   (w_beat),
                    .i_load (w_load),
                    .i_a    (a_col[gi]),
                    .i_b    (b_row[gj]),
                    .o_acc  (result[gi][gj])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_matmul_stream.sv
// Self-checking bench: table vectors, directed multi-cycle sequences, random vs. matrix model.
module tb_matmul_stream;

    localparam int L  = 2;
    localparam int M  = 3;
    localparam int R  = 4;
    localparam int DW = 16;
    localparam int AW = 34;

    typedef logic [DW-1:0] dat_t;

    typedef struct packed {
        logic [1:0]        sel;
        logic [5:0][15:0]  a;
        logic [11:0][15:0] b;
        logic [7:0][33:0]  c;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, clear, in_valid, out_ready;
    dat_t a_col [L];
    dat_t b_row [R];

    logic          in_ready_s, out_valid_s, busy_s;
    logic [AW-1:0] result_s [L][R];
    logic          in_ready_u, out_valid_u, busy_u;
    logic [AW-1:0] result_u [L][R];
    logic          in_ready_w, out_valid_w, busy_w;
    logic [7:0]    result_w [L][R];
    logic          in_ready_m, out_valid_m, busy_m;
    logic [31:0]   result_m [L][R];

    matmul_stream u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .busy(busy_s)
    );

    matmul_stream #(.SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_u),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_u), .out_ready(out_ready),
        .result(result_u), .busy(busy_u)
    );

    matmul_stream #(.SIGNED(0), .ACC_W(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .busy(busy_w)
    );

    matmul_stream #(.MIDDLE_SIZE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_m),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_m), .out_ready(out_ready),
        .result(result_m), .busy(busy_m)
    );

    int checks = 0;
    int errors = 0;

    dat_t        ma [L][M];
    dat_t        mb [M][R];
    logic [63:0] mc [L][R];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] get_res(input int sel, input int i, input int j);
        case (sel)
            0:       return 64'(result_s[i][j]);
            1:       return 64'(result_u[i][j]);
            2:       return 64'(result_w[i][j]);
            default: return 64'(result_m[i][j]);
        endcase
    endfunction

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return out_valid_s;
            1:       return out_valid_u;
            2:       return out_valid_w;
            default: return out_valid_m;
        endcase
    endfunction

    task automatic chk_mat(input string name, input int sel);
        bit          bad;
        int          bi, bj;
        logic [63:0] act;
        bad = 0; bi = 0; bj = 0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < R; j++) begin
                if (!bad && (get_res(sel, i, j) !== mc[i][j])) begin
                    bad = 1; bi = i; bj = j;
                end
            end
        end
        checks++;
        if (bad) begin
            errors++;
            act = get_res(sel, bi, bj);
            $display("FAIL %s C[%0d][%0d] got %0h want %0h", name, bi, bj, act, mc[bi][bj]);
        end
    endtask

    // Plain matrix product of the first nk beats, reduced to aw bits.
    function automatic void model_c(input bit sgn, input int aw, input int nk);
        longint s, x, y;
        logic [63:0] u;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < R; j++) begin
                s = 0;
                for (int k = 0; k < nk; k++) begin
                    x = sgn ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
                    y = sgn ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
                    s += x * y;
                end
                u = s;
                if (aw < 64) u = u & ((64'd1 << aw) - 64'd1);
                mc[i][j] = u;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_rand();
        for (int i = 0; i < L; i++)
            for (int k = 0; k < M; k++) ma[i][k] = dat_t'($urandom);
        for (int k = 0; k < M; k++)
            for (int j = 0; j < R; j++) mb[k][j] = dat_t'($urandom);
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < L; i++) a_col[i] = ma[i][k];
        for (int j = 0; j < R; j++) b_row[j] = mb[k][j];
        in_valid = 1'b1;
    endtask

    task automatic run_beats(input int k0, input int k1, input logic rdy);
        out_ready = rdy;
        for (int k = k0; k <= k1; k++) begin
            drive_beat(k);
            #1;
            chk("beat_in_ready", 64'(in_ready_s), 64'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk_vec(input logic [1:0] sel, input logic [15:0] av,
                                    input logic [15:0] bv, input logic [33:0] cv);
        vec_t v;
        v.sel = sel;
        for (int n = 0; n < 6; n++)  v.a[n] = av;
        for (int n = 0; n < 12; n++) v.b[n] = bv;
        for (int n = 0; n < 8; n++)  v.c[n] = cv;
        return v;
    endfunction

    vec_t vecs [7];
    int   mk;
    bit   mhold;
    logic exp_rdy;

    initial begin
        longint c1 [8];
        c1 = '{38, 44, 50, 56, 83, 98, 113, 128};
        vecs[0].sel = 2'd0;
        for (int n = 0; n < 6; n++)  vecs[0].a[n] = 16'(n + 1);
        for (int n = 0; n < 12; n++) vecs[0].b[n] = 16'(n + 1);
        for (int n = 0; n < 8; n++)  vecs[0].c[n] = 34'(c1[n]);
        vecs[1] = mk_vec(2'd0, 16'hFFFF, 16'h7FFF, 34'(-98301));
        vecs[2] = mk_vec(2'd1, 16'hFFFF, 16'hFFFF, 34'd12884508675);
        vecs[3] = mk_vec(2'd0, 16'hFFFF, 16'hFFFF, 34'd3);
        vecs[4] = mk_vec(2'd2, 16'd16, 16'd16, 34'd0);
        vecs[5] = mk_vec(2'd1, 16'd16, 16'd16, 34'd768);
        vecs[6] = mk_vec(2'd0, 16'h8000, 16'h8000, 34'd3221225472);

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < L; i++) a_col[i] = '0;
        for (int j = 0; j < R; j++) b_row[j] = '0;
        #12;
        chk("reset_out_valid", 64'(out_valid_s), 64'd0);
        chk("reset_busy", 64'(busy_s), 64'd0);
        chk("reset_in_ready", 64'(in_ready_s), 64'd1);
        for (int i = 0; i < L; i++) for (int j = 0; j < R; j++) mc[i][j] = '0;
        chk_mat("reset_result", 0);
        #1 rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < L; i++)
                for (int k = 0; k < M; k++) ma[i][k] = vecs[v].a[i*M + k];
            for (int k = 0; k < M; k++)
                for (int j = 0; j < R; j++) mb[k][j] = vecs[v].b[k*R + j];
            for (int i = 0; i < L; i++)
                for (int j = 0; j < R; j++) mc[i][j] = 64'(vecs[v].c[i*R + j]);
            run_beats(0, M - 1, 1'b1);
            chk("vec_out_valid", 64'(get_ov(int'(vecs[v].sel))), 64'd1);
            chk_mat("vec_result", int'(vecs[v].sel));
            $display("vec %0d sel %0d checked", v, vecs[v].sel);
            tick();
            chk("vec_one_cycle", 64'(get_ov(int'(vecs[v].sel))), 64'd0);
        end

        // Hold with out_ready low: result frozen, beats refused.
        gen_rand();
        model_c(1, AW, M);
        run_beats(0, M - 1, 1'b0);
        chk("hold_out_valid", 64'(out_valid_s), 64'd1);
        chk_mat("hold_result", 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            for (int i = 0; i < L; i++) a_col[i] = dat_t'($urandom);
            #1;
            chk("hold_in_ready", 64'(in_ready_s), 64'd0);
            tick();
            chk("hold_ov_stays", 64'(out_valid_s), 64'd1);
            chk_mat("hold_stable", 0);
        end
        gen_rand();
        model_c(1, AW, M);
        out_ready = 1'b1;
        drive_beat(0);
        #1;
        chk("release_in_ready", 64'(in_ready_s), 64'd1);
        tick();
        chk("release_ov_low", 64'(out_valid_s), 64'd0);
        chk("release_busy", 64'(busy_s), 64'd1);
        run_beats(1, M - 1, 1'b1);
        chk("release_next_ov", 64'(out_valid_s), 64'd1);
        chk_mat("release_next_c", 0);
        $display("hold sequence checked");
        tick();

        // Back-to-back: six beats on six consecutive edges.
        gen_rand();
        model_c(1, AW, M);
        run_beats(0, M - 1, 1'b1);
        chk("b2b_first_ov", 64'(out_valid_s), 64'd1);
        chk_mat("b2b_first_c", 0);
        gen_rand();
        model_c(1, AW, M);
        drive_beat(0);
        #1;
        chk("b2b_in_ready", 64'(in_ready_s), 64'd1);
        tick();
        chk("b2b_ov_low", 64'(out_valid_s), 64'd0);
        chk("b2b_busy", 64'(busy_s), 64'd1);
        run_beats(1, M - 1, 1'b1);
        chk("b2b_second_ov", 64'(out_valid_s), 64'd1);
        chk_mat("b2b_second_c", 0);
        $display("back-to-back sequence checked");
        tick();

        // Clear mid-matrix.
        gen_rand();
        run_beats(0, 1, 1'b1);
        chk("clr_busy_before", 64'(busy_s), 64'd1);
        clear = 1'b1;
        drive_beat(2);
        #1;
        chk("clr_in_ready", 64'(in_ready_s), 64'd0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy_after", 64'(busy_s), 64'd0);
        chk("clr_out_valid", 64'(out_valid_s), 64'd0);
        gen_rand();
        model_c(1, AW, M);
        run_beats(0, M - 1, 1'b1);
        chk("clr_new_ov", 64'(out_valid_s), 64'd1);
        chk_mat("clr_new_c", 0);
        $display("clear sequence checked");
        tick();

        // Asynchronous reset mid-matrix.
        gen_rand();
        run_beats(0, 1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ov", 64'(out_valid_s), 64'd0);
        chk("rst_mid_busy", 64'(busy_s), 64'd0);
        for (int i = 0; i < L; i++) for (int j = 0; j < R; j++) mc[i][j] = '0;
        chk_mat("rst_mid_zero", 0);
        #1 rst_n = 1'b1;
        gen_rand();
        model_c(1, AW, M);
        run_beats(0, M - 1, 1'b1);
        chk("rst_new_ov", 64'(out_valid_s), 64'd1);
        chk_mat("rst_new_c", 0);
        $display("reset sequence checked");
        tick();

        // MIDDLE_SIZE=1: handshake plus beat keeps out_valid high with the new C.
        gen_rand();
        model_c(1, 32, 1);
        out_ready = 1'b1;
        drive_beat(0);
        #1;
        chk("m1_in_ready", 64'(in_ready_m), 64'd1);
        tick();
        chk("m1_ov", 64'(out_valid_m), 64'd1);
        chk_mat("m1_c_first", 3);
        gen_rand();
        model_c(1, 32, 1);
        drive_beat(0);
        #1;
        chk("m1_in_ready_hold", 64'(in_ready_m), 64'd1);
        tick();
        chk("m1_ov_stays", 64'(out_valid_m), 64'd1);
        chk_mat("m1_c_second", 3);
        in_valid = 1'b0;
        tick();
        chk("m1_ov_drop", 64'(out_valid_m), 64'd0);
        $display("middle=1 sequence checked");

        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Random traffic against the matrix-level model.
        mk = 0;
        mhold = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < L; i++) a_col[i] = dat_t'($urandom);
            for (int j = 0; j < R; j++) b_row[j] = dat_t'($urandom);
            #1;
            exp_rdy = !clear && (!mhold || out_ready);
            chk("rand_in_ready", 64'(in_ready_s), 64'(exp_rdy));
            if (clear) begin
                mk = 0;
                mhold = 0;
            end else begin
                if (mhold && out_ready) mhold = 0;
                if (in_valid && exp_rdy) begin
                    for (int i = 0; i < L; i++) ma[i][mk] = a_col[i];
                    for (int j = 0; j < R; j++) mb[mk][j] = b_row[j];
                    mk++;
                    if (mk == M) begin
                        mk = 0;
                        model_c(1, AW, M);
                        mhold = 1;
                    end
                end
            end
            tick();
            chk("rand_out_valid", 64'(out_valid_s), 64'(mhold));
            chk("rand_busy", 64'(busy_s), 64'(mk != 0));
            if (mhold) chk_mat("rand_result", 0);
        end
        in_valid = 1'b0;
        clear = 1'b0;
        $display("random phase done, %0d checks so far", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
